// File: rtl/fir_tap_sequencer.sv
// Control sequencer for a single-MAC, time-multiplexed FIR datapath.
// Handles sample intake, circular delay-line writes, the tap sweep and delay-line zero-fill.
module fir_tap_sequencer #(
  parameter int N_TAPS     = 21,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int MAC_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic                  flush_req,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic                  mac_last,
  output logic                  y_valid,
  output logic                  busy
);

  localparam int CW = (ADDR_WIDTH + 1 > 4) ? ADDR_WIDTH + 1 : 4;
  localparam logic [CW-1:0]         LAST_TAP   = CW'(N_TAPS - 1);
  localparam logic [CW-1:0]         LAST_DRAIN = (MAC_LAT > 0) ? CW'(MAC_LAT - 1) : '0;
  localparam logic [CW-1:0]         TAPS_EXT   = CW'(N_TAPS);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(N_TAPS - 1);

  typedef enum logic [2:0] {FLUSH, IDLE, WRITE, MAC, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] samp_q, samp_d;

  logic                  wr_en_nx, mac_en_nx, mac_clr_nx, mac_last_nx;
  logic                  y_valid_nx, x_ready_nx, busy_nx;
  logic [ADDR_WIDTH-1:0] wr_addr_nx, rd_addr_nx, coef_addr_nx;
  logic [DATA_WIDTH-1:0] wr_data_nx;
  logic [CW-1:0]         wp_ext, rd_diff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    pend_d  = pend_q;
    samp_d  = samp_q;
    if (flush_req && state_q != FLUSH) pend_d = 1'b1;
    case (state_q)
      FLUSH: begin
        // Outputs show the next state, so right after reset (wr_en still low)
        // index 0 has not been presented yet and must not be skipped.
        if (!wr_en) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_TAP) begin
          state_d = IDLE;
          cnt_d   = '0;
          wptr_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        if (pend_d) begin
          state_d = FLUSH;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (x_valid) begin
          state_d = WRITE;
          samp_d  = x_in;
        end
      end
      WRITE: begin
        state_d = MAC;
        cnt_d   = '0;
      end
      MAC: begin
        if (cnt_q == LAST_TAP) begin
          cnt_d   = '0;
          state_d = (MAC_LAT == 0) ? DONE : DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + ADDR_WIDTH'(1);
        cnt_d  = '0;
        if (pend_d) begin
          state_d = FLUSH;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered Moore outputs are decoded from the state being entered.
  always_comb begin
    wr_en_nx     = 1'b0;
    wr_addr_nx   = '0;
    wr_data_nx   = '0;
    rd_addr_nx   = '0;
    coef_addr_nx = '0;
    mac_en_nx    = 1'b0;
    mac_clr_nx   = 1'b0;
    mac_last_nx  = 1'b0;
    y_valid_nx   = (state_d == DONE);
    x_ready_nx   = (state_d == IDLE);
    busy_nx      = (state_d != IDLE);
    wp_ext       = CW'(wptr_d);
    rd_diff      = (wp_ext >= cnt_d) ? wp_ext - cnt_d : wp_ext + TAPS_EXT - cnt_d;
    case (state_d)
      FLUSH: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = cnt_d[ADDR_WIDTH-1:0];
      end
      WRITE: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = wptr_d;
        wr_data_nx = samp_d;
      end
      MAC: begin
        mac_en_nx    = 1'b1;
        coef_addr_nx = cnt_d[ADDR_WIDTH-1:0];
        rd_addr_nx   = rd_diff[ADDR_WIDTH-1:0];
        mac_clr_nx   = (cnt_d == '0);
        mac_last_nx  = (cnt_d == LAST_TAP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FLUSH;
      cnt_q     <= '0;
      wptr_q    <= '0;
      pend_q    <= 1'b0;
      samp_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      coef_addr <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_last  <= 1'b0;
      y_valid   <= 1'b0;
      x_ready   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      pend_q    <= pend_d;
      samp_q    <= samp_d;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      rd_addr   <= rd_addr_nx;
      coef_addr <= coef_addr_nx;
      mac_en    <= mac_en_nx;
      mac_clr   <= mac_clr_nx;
      mac_last  <= mac_last_nx;
      y_valid   <= y_valid_nx;
      x_ready   <= x_ready_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed self-checking bench for fir_tap_sequencer at default parameters.
module tb_fir_tap_sequencer;

  localparam int N  = 21;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic          flush_req = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_en, mac_clr, mac_last, y_valid, busy;
  logic [37:0]   all_out;

  int vec  = 0;
  int errs = 0;

  assign all_out = {wr_en, wr_addr, wr_data, rd_addr, coef_addr,
                    mac_en, mac_clr, mac_last, y_valid, x_ready, busy};

  always #5 clk = ~clk;

  fir_tap_sequencer #(.N_TAPS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAC_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .flush_req(flush_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .coef_addr(coef_addr), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_last(mac_last), .y_valid(y_valid), .busy(busy)
  );

  task automatic test_reset();
    rst_n = 1'b0; x_valid = 1'b0; flush_req = 1'b0; x_in = '0;
    repeat (3) @(negedge clk);
    vec++;
    if (all_out !== '0) begin
      errs++; $display("FAIL reset_outputs got %h exp 0", all_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vec++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== '0 || busy !== 1'b1 ||
          mac_en !== 1'b0 || y_valid !== 1'b0 || x_ready !== 1'b0) begin
        errs++;
        $display("FAIL reset_flush[%0d] got we=%b a=%0d d=%h busy=%b mac=%b y=%b rdy=%b exp we=1 a=%0d d=0 busy=1 mac=0 y=0 rdy=0",
                 i, wr_en, wr_addr, wr_data, busy, mac_en, y_valid, x_ready, i);
      end
    end
    @(negedge clk);
    vec++;
    if (x_ready !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      errs++; $display("FAIL reset_idle got rdy=%b busy=%b we=%b exp 1 0 0", x_ready, busy, wr_en);
    end
  endtask

  task automatic test_single();
    int exp_rd;
    x_in = 16'h1234; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0; x_in = '0;
    vec++;
    if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 16'h1234 || x_ready !== 1'b0) begin
      errs++; $display("FAIL single_write got we=%b a=%0d d=%h rdy=%b exp 1 0 1234 0", wr_en, wr_addr, wr_data, x_ready);
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      exp_rd = (N - k) % N;
      vec++;
      if (mac_en !== 1'b1 || coef_addr !== AW'(k) || rd_addr !== AW'(exp_rd) ||
          mac_clr !== (k == 0) || mac_last !== (k == N - 1) || y_valid !== 1'b0) begin
        errs++;
        $display("FAIL single_tap[%0d] got en=%b c=%0d r=%0d clr=%b last=%b y=%b exp en=1 c=%0d r=%0d clr=%b last=%b y=0",
                 k, mac_en, coef_addr, rd_addr, mac_clr, mac_last, y_valid, k, exp_rd, k == 0, k == N - 1);
      end
    end
    for (int d = 0; d < ML; d++) begin
      @(negedge clk);
      vec++;
      if (mac_en !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b1 || wr_en !== 1'b0) begin
        errs++; $display("FAIL single_drain[%0d] got mac=%b y=%b busy=%b we=%b exp 0 0 1 0", d, mac_en, y_valid, busy, wr_en);
      end
    end
    @(negedge clk);
    vec++;
    if (y_valid !== 1'b1 || x_ready !== 1'b0) begin
      errs++; $display("FAIL single_done got y=%b rdy=%b exp 1 0", y_valid, x_ready);
    end
    @(negedge clk);
    vec++;
    if (y_valid !== 1'b0 || x_ready !== 1'b1) begin
      errs++; $display("FAIL single_ready got y=%b rdy=%b exp 0 1", y_valid, x_ready);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] sine [16] = '{16'h0000, 16'h30FB, 16'h5A82, 16'h7641, 16'h7FFF, 16'h7641,
                                 16'h5A82, 16'h30FB, 16'h0000, 16'hCF05, 16'hA57E, 16'h89BF,
                                 16'h8001, 16'h89BF, 16'hA57E, 16'hCF05};
    int accepts = 0, ycnt = 0, since = -1, last_acc = -1, wp = 1, k, exp_rd;
    logic [DW-1:0] exp_d = '0;
    x_valid = 1'b1;
    for (int n = 0; n < 546; n++) begin
      if (y_valid === 1'b1) ycnt++;
      x_in = sine[(n * (1 + n / 64)) % 16];
      if (x_ready === 1'b1 && x_valid === 1'b1) begin
        if (last_acc >= 0) begin
          vec++;
          if (n - last_acc != 26) begin
            errs++; $display("FAIL stream_period got %0d exp 26", n - last_acc);
          end
        end
        last_acc = n; accepts++; exp_d = x_in; since = 0;
      end else if (since >= 0) begin
        since++;
        if (since == 1) begin
          if (accepts == 21) x_valid = 1'b0;
          vec++;
          if (wr_en !== 1'b1 || wr_addr !== AW'(wp) || wr_data !== exp_d) begin
            errs++; $display("FAIL stream_write[%0d] got we=%b a=%0d d=%h exp 1 %0d %h", accepts, wr_en, wr_addr, wr_data, wp, exp_d);
          end
        end else if (since >= 2 && since <= N + 1) begin
          k = since - 2;
          exp_rd = (wp - k + N) % N;
          vec++;
          if (mac_en !== 1'b1 || rd_addr !== AW'(exp_rd) || coef_addr !== AW'(k)) begin
            errs++; $display("FAIL stream_tap[%0d.%0d] got en=%b r=%0d c=%0d exp 1 %0d %0d", accepts, k, mac_en, rd_addr, coef_addr, exp_rd, k);
          end
        end else if (since == N + 2 + ML) begin
          vec++;
          if (y_valid !== 1'b1) begin
            errs++; $display("FAIL stream_done[%0d] got y=%b exp 1", accepts, y_valid);
          end
          wp = (wp + 1) % N;
        end
      end
      @(negedge clk);
    end
    x_valid = 1'b0;
    vec++;
    if (accepts != 21) begin
      errs++; $display("FAIL stream_accepts got %0d exp 21", accepts);
    end
    vec++;
    if (ycnt != 21) begin
      errs++; $display("FAIL stream_yvalid_count got %0d exp 21", ycnt);
    end
    vec++;
    if (x_ready !== 1'b1) begin
      errs++; $display("FAIL stream_end_ready got %b exp 1", x_ready);
    end
  endtask

  task automatic test_flush_collide();
    int ycnt = 0, waited = 0;
    flush_req = 1'b1; x_valid = 1'b1; x_in = 16'hBEEF;
    @(negedge clk);
    flush_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      vec++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== '0 || x_ready !== 1'b0 || mac_en !== 1'b0) begin
        errs++; $display("FAIL collide_flush[%0d] got we=%b a=%0d d=%h rdy=%b mac=%b exp 1 %0d 0 0 0", i, wr_en, wr_addr, wr_data, x_ready, mac_en, i);
      end
    end
    @(negedge clk);
    vec++;
    if (x_ready !== 1'b1) begin
      errs++; $display("FAIL collide_idle got rdy=%b exp 1", x_ready);
    end
    @(negedge clk);
    x_valid = 1'b0;
    vec++;
    if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 16'hBEEF) begin
      errs++; $display("FAIL collide_accept got we=%b a=%0d d=%h exp 1 0 beef", wr_en, wr_addr, wr_data);
    end
    while (x_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
      if (y_valid === 1'b1) ycnt++;
    end
    vec++;
    if (x_ready !== 1'b1 || ycnt != 1) begin
      errs++; $display("FAIL collide_complete got rdy=%b y=%0d exp 1 1", x_ready, ycnt);
    end
  endtask

  task automatic test_flush_in_mac();
    x_in = 16'h0042; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    vec++;
    if (wr_en !== 1'b1 || wr_addr !== AW'(1) || wr_data !== 16'h0042) begin
      errs++; $display("FAIL macflush_write got we=%b a=%0d d=%h exp 1 1 0042", wr_en, wr_addr, wr_data);
    end
    for (int s = 2; s <= N + 2 + ML; s++) begin
      @(negedge clk);
      flush_req = (s == 5 || s == 10);
      if (s == N + 2 + ML) begin
        vec++;
        if (y_valid !== 1'b1) begin
          errs++; $display("FAIL macflush_done got y=%b exp 1", y_valid);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vec++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== '0 || busy !== 1'b1) begin
        errs++; $display("FAIL macflush_flush[%0d] got we=%b a=%0d d=%h busy=%b exp 1 %0d 0 1", i, wr_en, wr_addr, wr_data, busy, i);
      end
    end
    @(negedge clk);
    vec++;
    if (x_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL macflush_single got rdy=%b busy=%b exp 1 0", x_ready, busy);
    end
  endtask

  task automatic test_reset_midop();
    int ycnt = 0;
    x_in = 16'h0077; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    vec++;
    if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 16'h0077) begin
      errs++; $display("FAIL midrst_wptr0 got we=%b a=%0d d=%h exp 1 0 0077", wr_en, wr_addr, wr_data);
    end
    for (int k = 0; k <= 10; k++) @(negedge clk);
    vec++;
    if (mac_en !== 1'b1 || coef_addr !== AW'(10)) begin
      errs++; $display("FAIL midrst_tap got en=%b c=%0d exp 1 10", mac_en, coef_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (all_out !== '0) begin
      errs++; $display("FAIL midrst_async got %h exp 0", all_out);
    end
    repeat (30) begin
      @(negedge clk);
      if (y_valid === 1'b1) ycnt++;
    end
    vec++;
    if (ycnt != 0) begin
      errs++; $display("FAIL midrst_no_y got %0d exp 0", ycnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vec++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== '0 || y_valid !== 1'b0) begin
        errs++; $display("FAIL midrst_flush[%0d] got we=%b a=%0d d=%h y=%b exp 1 %0d 0 0", i, wr_en, wr_addr, wr_data, y_valid, i);
      end
    end
    @(negedge clk);
    vec++;
    if (x_ready !== 1'b1) begin
      errs++; $display("FAIL midrst_idle got rdy=%b exp 1", x_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_flush_collide();
    test_flush_in_mac();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
